// File: rtl/lcd_pkg.sv
// Shared types, constants and address helpers for the HD44780-style bus receiver.
// Addresses are in LCD space: line 1 at 0x00-0x27, line 2 at 0x40-0x67.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_WAIT  = 2'd2
  } lcd_state_e;

  typedef enum logic [3:0] {
    CLS_NOP,
    CLS_CLEAR,
    CLS_HOME,
    CLS_ENTRY,
    CLS_DISPLAY,
    CLS_SHIFT,
    CLS_FUNC,
    CLS_CGRAM,
    CLS_DDRAM
  } cmd_class_e;

  localparam logic [6:0] LINE1_END   = 7'h27;
  localparam logic [6:0] LINE2_BASE  = 7'h40;
  localparam logic [6:0] LINE2_END   = 7'h67;
  localparam logic [7:0] SPACE       = 8'h20;
  localparam int         DDRAM_DEPTH = 80;
  localparam logic [5:0] SHIFT_LAST  = 6'd39;

  // Instruction class is set by the highest set bit of the byte.
  function automatic cmd_class_e classify(input logic [7:0] b);
    casez (b)
      8'b1???????: return CLS_DDRAM;
      8'b01??????: return CLS_CGRAM;
      8'b001?????: return CLS_FUNC;
      8'b0001????: return CLS_SHIFT;
      8'b00001???: return CLS_DISPLAY;
      8'b000001??: return CLS_ENTRY;
      8'b0000001?: return CLS_HOME;
      8'b00000001: return CLS_CLEAR;
      default:     return CLS_NOP;
    endcase
  endfunction

  function automatic logic addr_valid(input logic [6:0] a);
    return (a <= LINE1_END) || ((a >= LINE2_BASE) && (a <= LINE2_END));
  endfunction

  function automatic logic [6:0] addr_inc(input logic [6:0] a);
    if (a == LINE1_END) return LINE2_BASE;
    if (a == LINE2_END) return 7'h00;
    return a + 7'd1;
  endfunction

  function automatic logic [6:0] addr_dec(input logic [6:0] a);
    if (a == 7'h00) return LINE2_END;
    if (a == LINE2_BASE) return LINE1_END;
    return a - 7'd1;
  endfunction

  // Line 2 is packed directly after line 1 in the 80-entry array.
  function automatic logic [6:0] addr_to_idx(input logic [6:0] a);
    return a[6] ? (7'(a[5:0]) + 7'd40) : a;
  endfunction

  function automatic logic [5:0] shift_step(input logic [5:0] s, input logic up);
    if (up) return (s == SHIFT_LAST) ? 6'd0 : s + 6'd1;
    return (s == 6'd0) ? SHIFT_LAST : s - 6'd1;
  endfunction

endpackage

// File: rtl/lcd_bus_receiver_ddram.sv
// 80x8 shadow DDRAM: one write port, one registered read port, both in LCD address space.
// A read and write to the same entry in one cycle returns the old byte.
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata,
  input  logic [6:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [DDRAM_DEPTH];
  logic [7:0] rdata_q, rdata_d;
  logic [6:0] widx, ridx;

  always_comb begin
    widx    = addr_to_idx(waddr);
    ridx    = addr_to_idx(raddr);
    rdata_d = addr_valid(raddr) ? mem[ridx] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (we && addr_valid(waddr)) mem[widx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rdata_q <= 8'h00;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lcd_bus_receiver.sv
// Receiving end of an 8-bit HD44780-style bus: samples writes on EN fall,
// keeps shadow display state and emulates the controller busy time.
//   state    | meaning
//   ST_IDLE  | ready, bus writes are accepted
//   ST_CLEAR | filling all 80 DDRAM entries with spaces, one per cycle
//   ST_WAIT  | busy countdown; writes arriving now are overruns
module lcd_bus_receiver
  import lcd_pkg::*;
#(
  parameter int BUSY_CYC    = 1850,
  parameter int CLEAR_CYC   = 76000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] lcd_data,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] cursor_addr,
  output logic [5:0] disp_shift,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       entry_shift,
  output logic       func_dl,
  output logic       func_n,
  output logic       func_f,
  output logic       busy,
  output logic       cmd_valid,
  output logic       cmd_rs,
  output logic [7:0] cmd_byte,
  output logic       err_overrun,
  output logic       err_addr,
  output logic       err_read
);

  localparam logic [31:0] BUSY_CNT   = 32'(BUSY_CYC);
  localparam logic [31:0] HOME_CNT   = 32'(CLEAR_CYC);
  localparam logic [31:0] CLEAR_TAIL = 32'(CLEAR_CYC - DDRAM_DEPTH);

  logic [SYNC_STAGES-1:0]      en_sync_q, en_sync_d, rs_sync_q, rs_sync_d, rw_sync_q, rw_sync_d;
  logic [SYNC_STAGES-1:0][7:0] data_sync_q, data_sync_d;
  logic                        en_prev_q, en_prev_d;
  lcd_state_e                  state_q, state_d;
  logic [31:0]                 cnt_q, cnt_d;
  logic [6:0]                  clr_addr_q, clr_addr_d, cursor_q, cursor_d;
  logic [5:0]                  shift_q, shift_d;
  logic display_on_q, display_on_d, cursor_on_q, cursor_on_d, blink_on_q, blink_on_d;
  logic entry_inc_q, entry_inc_d, entry_shift_q, entry_shift_d;
  logic func_dl_q, func_dl_d, func_n_q, func_n_d, func_f_q, func_f_d;
  logic ddram_mode_q, ddram_mode_d, busy_q, busy_d;
  logic cmd_valid_q, cmd_valid_d, cmd_rs_q, cmd_rs_d;
  logic [7:0] cmd_byte_q, cmd_byte_d;
  logic err_overrun_q, err_overrun_d, err_addr_q, err_addr_d, err_read_q, err_read_d;

  logic       bus_rs, bus_rw, en_fall, ram_we;
  logic [7:0] bus_data, ram_wdata;
  logic [6:0] ram_waddr;

  // RS, RW and data come from the same synchroniser stage as the EN used for edge detect.
  assign bus_rs   = rs_sync_q[SYNC_STAGES-1];
  assign bus_rw   = rw_sync_q[SYNC_STAGES-1];
  assign bus_data = data_sync_q[SYNC_STAGES-1];
  assign en_fall  = en_prev_q & ~en_sync_q[SYNC_STAGES-1];

  always_comb begin
    en_sync_d     = {en_sync_q[SYNC_STAGES-2:0], lcd_en};
    rs_sync_d     = {rs_sync_q[SYNC_STAGES-2:0], lcd_rs};
    rw_sync_d     = {rw_sync_q[SYNC_STAGES-2:0], lcd_rw};
    data_sync_d   = {data_sync_q[SYNC_STAGES-2:0], lcd_data};
    en_prev_d     = en_sync_q[SYNC_STAGES-1];
    state_d       = state_q;
    cnt_d         = cnt_q;
    clr_addr_d    = clr_addr_q;
    cursor_d      = cursor_q;
    shift_d       = shift_q;
    display_on_d  = display_on_q;
    cursor_on_d   = cursor_on_q;
    blink_on_d    = blink_on_q;
    entry_inc_d   = entry_inc_q;
    entry_shift_d = entry_shift_q;
    func_dl_d     = func_dl_q;
    func_n_d      = func_n_q;
    func_f_d      = func_f_q;
    ddram_mode_d  = ddram_mode_q;
    cmd_valid_d   = 1'b0;
    cmd_rs_d      = cmd_rs_q;
    cmd_byte_d    = cmd_byte_q;
    err_overrun_d = err_overrun_q;
    err_addr_d    = err_addr_q;
    err_read_d    = err_read_q;
    ram_we        = 1'b0;
    ram_waddr     = cursor_q;
    ram_wdata     = bus_data;

    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_addr_q;
        ram_wdata = SPACE;
        if (clr_addr_q == LINE2_END) begin
          state_d    = ST_WAIT;
          cnt_d      = CLEAR_TAIL;
          clr_addr_d = 7'h00;
        end else begin
          clr_addr_d = addr_inc(clr_addr_q);
        end
      end
      ST_WAIT: begin
        if (cnt_q == 32'd0) state_d = ST_IDLE;
        else                cnt_d   = cnt_q - 32'd1;
      end
      default: ;
    endcase

    if (en_fall) begin
      if (bus_rw) begin
        err_read_d = 1'b1;
      end else if (state_q != ST_IDLE) begin
        err_overrun_d = 1'b1;
      end else begin
        cmd_valid_d = 1'b1;
        cmd_rs_d    = bus_rs;
        cmd_byte_d  = bus_data;
        state_d     = ST_WAIT;
        cnt_d       = BUSY_CNT;
        if (bus_rs) begin
          if (ddram_mode_q) begin
            ram_we   = 1'b1;
            cursor_d = entry_inc_q ? addr_inc(cursor_q) : addr_dec(cursor_q);
            if (entry_shift_q) shift_d = shift_step(shift_q, entry_inc_q);
          end
        end else begin
          case (classify(bus_data))
            CLS_CLEAR: begin
              state_d     = ST_CLEAR;
              clr_addr_d  = 7'h00;
              cursor_d    = 7'h00;
              shift_d     = 6'd0;
              entry_inc_d = 1'b1;
            end
            CLS_HOME: begin
              cursor_d = 7'h00;
              shift_d  = 6'd0;
              cnt_d    = HOME_CNT;
            end
            CLS_ENTRY: begin
              entry_inc_d   = bus_data[1];
              entry_shift_d = bus_data[0];
            end
            CLS_DISPLAY: begin
              display_on_d = bus_data[2];
              cursor_on_d  = bus_data[1];
              blink_on_d   = bus_data[0];
            end
            CLS_SHIFT: begin
              if (bus_data[3]) shift_d  = shift_step(shift_q, bus_data[2]);
              else             cursor_d = bus_data[2] ? addr_inc(cursor_q) : addr_dec(cursor_q);
            end
            CLS_FUNC: begin
              func_dl_d = bus_data[4];
              func_n_d  = bus_data[3];
              func_f_d  = bus_data[2];
            end
            CLS_CGRAM: ddram_mode_d = 1'b0;
            CLS_DDRAM: begin
              ddram_mode_d = 1'b1;
              if (addr_valid(bus_data[6:0])) cursor_d   = bus_data[6:0];
              else                           err_addr_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_sync_q     <= '0;
      rs_sync_q     <= '0;
      rw_sync_q     <= '0;
      data_sync_q   <= '0;
      en_prev_q     <= 1'b0;
      state_q       <= ST_CLEAR;
      cnt_q         <= 32'd0;
      clr_addr_q    <= 7'h00;
      cursor_q      <= 7'h00;
      shift_q       <= 6'd0;
      display_on_q  <= 1'b0;
      cursor_on_q   <= 1'b0;
      blink_on_q    <= 1'b0;
      entry_inc_q   <= 1'b1;
      entry_shift_q <= 1'b0;
      func_dl_q     <= 1'b1;
      func_n_q      <= 1'b0;
      func_f_q      <= 1'b0;
      ddram_mode_q  <= 1'b1;
      busy_q        <= 1'b1;
      cmd_valid_q   <= 1'b0;
      cmd_rs_q      <= 1'b0;
      cmd_byte_q    <= 8'h00;
      err_overrun_q <= 1'b0;
      err_addr_q    <= 1'b0;
      err_read_q    <= 1'b0;
    end else begin
      en_sync_q     <= en_sync_d;
      rs_sync_q     <= rs_sync_d;
      rw_sync_q     <= rw_sync_d;
      data_sync_q   <= data_sync_d;
      en_prev_q     <= en_prev_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      clr_addr_q    <= clr_addr_d;
      cursor_q      <= cursor_d;
      shift_q       <= shift_d;
      display_on_q  <= display_on_d;
      cursor_on_q   <= cursor_on_d;
      blink_on_q    <= blink_on_d;
      entry_inc_q   <= entry_inc_d;
      entry_shift_q <= entry_shift_d;
      func_dl_q     <= func_dl_d;
      func_n_q      <= func_n_d;
      func_f_q      <= func_f_d;
      ddram_mode_q  <= ddram_mode_d;
      busy_q        <= busy_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_rs_q      <= cmd_rs_d;
      cmd_byte_q    <= cmd_byte_d;
      err_overrun_q <= err_overrun_d;
      err_addr_q    <= err_addr_d;
      err_read_q    <= err_read_d;
    end
  end

  lcd_ddram u_ddram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we & rst_n),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign cursor_addr = cursor_q;
  assign disp_shift  = shift_q;
  assign display_on  = display_on_q;
  assign cursor_on   = cursor_on_q;
  assign blink_on    = blink_on_q;
  assign entry_inc   = entry_inc_q;
  assign entry_shift = entry_shift_q;
  assign func_dl     = func_dl_q;
  assign func_n      = func_n_q;
  assign func_f      = func_f_q;
  assign busy        = busy_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_rs      = cmd_rs_q;
  assign cmd_byte    = cmd_byte_q;
  assign err_overrun = err_overrun_q;
  assign err_addr    = err_addr_q;
  assign err_read    = err_read_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Bench for lcd_bus_receiver: directed firmware-like sequences plus random writes,
// checked against a display model built on linear cursor positions 0..79.
module tb_lcd_bus_receiver;

  localparam int BUSY_CYC    = 20;
  localparam int CLEAR_CYC   = 150;
  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic       lcd_en = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [6:0] rd_addr = 7'h00;
  logic [7:0] rd_data, cmd_byte;
  logic [6:0] cursor_addr;
  logic [5:0] disp_shift;
  logic display_on, cursor_on, blink_on, entry_inc, entry_shift;
  logic func_dl, func_n, func_f, busy, cmd_valid, cmd_rs;
  logic err_overrun, err_addr, err_read;

  always #5 clk = ~clk;

  lcd_bus_receiver #(.BUSY_CYC(BUSY_CYC), .CLEAR_CYC(CLEAR_CYC), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_data(lcd_data), .lcd_en(lcd_en), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .rd_addr(rd_addr), .rd_data(rd_data), .cursor_addr(cursor_addr),
    .disp_shift(disp_shift), .display_on(display_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .entry_inc(entry_inc), .entry_shift(entry_shift),
    .func_dl(func_dl), .func_n(func_n), .func_f(func_f), .busy(busy),
    .cmd_valid(cmd_valid), .cmd_rs(cmd_rs), .cmd_byte(cmd_byte),
    .err_overrun(err_overrun), .err_addr(err_addr), .err_read(err_read)
  );

  int checks = 0;
  int failures = 0;
  int n_cmd = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_e;

  // Display model: cursor is a linear position 0..79, line 2 starts at position 40.
  logic [7:0] m_mem [128];
  int m_pos, m_shift;
  logic m_inc, m_es, m_don, m_con, m_bon, m_dl, m_n, m_f, m_ddram, m_eo, m_ea, m_er;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] pos2addr(input int p);
    return (p < 40) ? 7'(p) : 7'(p - 40 + 64);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_mem[i] = 8'h00;
    for (int p = 0; p < 80; p++) m_mem[pos2addr(p)] = 8'h20;
    m_pos = 0; m_shift = 0;
    m_inc = 1; m_es = 0; m_don = 0; m_con = 0; m_bon = 0;
    m_dl = 1; m_n = 0; m_f = 0; m_ddram = 1;
    m_eo = 0; m_ea = 0; m_er = 0;
  endtask

  task automatic model_apply(input logic rs, input logic [7:0] b);
    int a;
    if (rs) begin
      if (m_ddram) begin
        m_mem[pos2addr(m_pos)] = b;
        m_pos = m_inc ? (m_pos + 1) % 80 : (m_pos + 79) % 80;
        if (m_es) m_shift = m_inc ? (m_shift + 1) % 40 : (m_shift + 39) % 40;
      end
    end else if (b >= 8'h80) begin
      m_ddram = 1;
      a = int'(b) - 128;
      if (a <= 39) m_pos = a;
      else if (a >= 64 && a <= 103) m_pos = a - 64 + 40;
      else m_ea = 1;
    end else if (b >= 8'h40) begin
      m_ddram = 0;
    end else if (b >= 8'h20) begin
      m_dl = b[4]; m_n = b[3]; m_f = b[2];
    end else if (b >= 8'h10) begin
      if (b[3]) m_shift = b[2] ? (m_shift + 1) % 40 : (m_shift + 39) % 40;
      else      m_pos   = b[2] ? (m_pos + 1) % 80 : (m_pos + 79) % 80;
    end else if (b >= 8'h08) begin
      m_don = b[2]; m_con = b[1]; m_bon = b[0];
    end else if (b >= 8'h04) begin
      m_inc = b[1]; m_es = b[0];
    end else if (b >= 8'h02) begin
      m_pos = 0; m_shift = 0;
    end else if (b == 8'h01) begin
      for (int p = 0; p < 80; p++) m_mem[pos2addr(p)] = 8'h20;
      m_pos = 0; m_shift = 0; m_inc = 1;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, " cursor_addr"}, cursor_addr, pos2addr(m_pos));
    chk({tag, " disp_shift"}, disp_shift, m_shift);
    chk({tag, " display_on"}, display_on, m_don);
    chk({tag, " cursor_on"}, cursor_on, m_con);
    chk({tag, " blink_on"}, blink_on, m_bon);
    chk({tag, " entry_inc"}, entry_inc, m_inc);
    chk({tag, " entry_shift"}, entry_shift, m_es);
    chk({tag, " func_dl"}, func_dl, m_dl);
    chk({tag, " func_n"}, func_n, m_n);
    chk({tag, " func_f"}, func_f, m_f);
    chk({tag, " err_overrun"}, err_overrun, m_eo);
    chk({tag, " err_addr"}, err_addr, m_ea);
    chk({tag, " err_read"}, err_read, m_er);
  endtask

  task automatic check_reset_outputs();
    chk("rst cursor_addr", cursor_addr, 0);
    chk("rst disp_shift", disp_shift, 0);
    chk("rst display_on", display_on, 0);
    chk("rst cursor_on", cursor_on, 0);
    chk("rst blink_on", blink_on, 0);
    chk("rst entry_inc", entry_inc, 1);
    chk("rst entry_shift", entry_shift, 0);
    chk("rst func_dl", func_dl, 1);
    chk("rst func_n", func_n, 0);
    chk("rst func_f", func_f, 0);
    chk("rst err_overrun", err_overrun, 0);
    chk("rst err_addr", err_addr, 0);
    chk("rst err_read", err_read, 0);
    chk("rst cmd_valid", cmd_valid, 0);
    chk("rst cmd_rs", cmd_rs, 0);
    chk("rst cmd_byte", cmd_byte, 0);
    chk("rst rd_data", rd_data, 0);
  endtask

  task automatic read_chk(input logic [6:0] a);
    @(negedge clk) rd_addr = a;
    @(negedge clk);
    chk($sformatf("ddram[0x%02h]", a), rd_data, m_mem[a]);
  endtask

  // Drive one EN pulse; data is held until past the synchroniser.
  task automatic bus_pulse(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
    repeat (2) @(negedge clk);
    lcd_en = 1'b0;
    repeat (4) @(negedge clk);
    lcd_rw = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++; failures++;
      $display("FAIL busy_timeout: busy still 1 after %0d cycles", n);
    end
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] b);
    int n;
    exp_q.push_back({rs, b});
    model_apply(rs, b);
    bus_pulse(rs, 1'b0, b);
    wait_idle(n);
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (cmd_valid === 1'b1) begin
      n_cmd++;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL cmd_unexpected: rs=%0b byte=0x%02h with nothing expected", cmd_rs, cmd_byte);
      end else begin
        exp_e = exp_q.pop_front();
        chk("cmd_rs", cmd_rs, exp_e[8]);
        chk("cmd_byte", cmd_byte, exp_e[7:0]);
      end
    end
  end

  initial begin
    int n, r, cnt0;
    logic rs;
    logic [7:0] b;

    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    chk("busy_after_release", busy, 1);
    wait_idle(n);
    chk("power_on_clear_len", (n >= CLEAR_CYC - 1 && n <= CLEAR_CYC + 2), 1);
    read_chk(7'h00); read_chk(7'h27); read_chk(7'h40); read_chk(7'h67);
    check_state("init");

    bus_write(0, 8'h38); bus_write(0, 8'h0C); bus_write(0, 8'h06); bus_write(1, 8'h41);
    check_state("setup");
    chk("setup func_n", func_n, 1);
    chk("setup display_on", display_on, 1);
    chk("setup cursor", cursor_addr, 7'h01);
    read_chk(7'h00);

    bus_write(0, 8'hA7); bus_write(1, 8'h5A);
    chk("wrap cursor", cursor_addr, 7'h40);
    read_chk(7'h27);

    bus_write(0, 8'h04); bus_write(0, 8'h80); bus_write(1, 8'h31);
    chk("dec wrap cursor", cursor_addr, 7'h67);
    read_chk(7'h00);

    bus_write(0, 8'hB0);
    chk("bad addr err_addr", err_addr, 1);
    chk("bad addr cursor", cursor_addr, 7'h67);
    check_state("bad_addr");

    cnt0 = n_cmd;
    exp_q.push_back({1'b1, 8'h43});
    model_apply(1, 8'h43);
    bus_pulse(1, 0, 8'h43);
    bus_pulse(1, 0, 8'h42);
    m_eo = 1;
    wait_idle(n);
    repeat (2) @(negedge clk);
    chk("overrun cmd count", n_cmd - cnt0, 1);
    chk("overrun flag", err_overrun, 1);
    check_state("overrun");
    read_chk(pos2addr(m_pos));
    read_chk(7'h67);

    bus_write(0, 8'h80);
    bus_write(0, 8'h07); bus_write(1, 8'h58);
    chk("entry shift disp_shift", disp_shift, 1);
    check_state("entry_shift");

    bus_pulse(0, 1, 8'h01);
    chk("read no busy", busy, 0);
    m_er = 1;
    check_state("rw_read");

    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 11);
      rs = 1'b0;
      case (r)
        0, 1, 2, 3, 4: begin rs = 1'b1; b = 8'($urandom_range(32, 126)); end
        5:  b = 8'h04 | 8'($urandom_range(0, 3));
        6:  b = 8'h08 | 8'($urandom_range(0, 7));
        7:  b = 8'h10 | 8'($urandom_range(0, 15));
        8:  b = 8'h80 | 8'($urandom_range(0, 127));
        9:  b = 8'h20 | 8'($urandom_range(0, 31));
        10: b = 8'h40 | 8'($urandom_range(0, 63));
        default: b = ($urandom_range(0, 3) == 0) ? 8'h01 : (8'h02 | 8'($urandom_range(0, 1)));
      endcase
      bus_write(rs, b);
      check_state($sformatf("rand%0d", k));
      read_chk(pos2addr($urandom_range(0, 79)));
    end

    bus_write(0, 8'h0F);
    exp_q.push_back({1'b0, 8'h01});
    model_apply(0, 8'h01);
    bus_pulse(0, 0, 8'h01);
    repeat (10) @(negedge clk);
    chk("mid clear busy", busy, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk("busy_after_rst2", busy, 1);
    wait_idle(n);
    chk("restart_clear_len", (n >= CLEAR_CYC - 1 && n <= CLEAR_CYC + 2), 1);
    check_state("after_rst2");
    read_chk(7'h00); read_chk(7'h13); read_chk(7'h27); read_chk(7'h40); read_chk(7'h67);

    repeat (5) @(negedge clk);
    chk("expected_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
